// File: rtl/bcd_pkg.sv
// Shared BCD types and constants, used by the encoder (binary_to_bcd_seq) and the decoder.
package bcd_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int ADJ_THRESHOLD = 5;
  localparam int ADJ_ADD       = 3;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
endpackage

// File: rtl/binary_to_bcd_seq_if.sv
// Request/result bus of binary_to_bcd_seq. Overflow exists only with BIN2BCD_OVERFLOW_EN.
interface binary_to_bcd_seq_if #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
);
  logic                  start;
  logic [WIDTH-1:0]      Binary;
  logic [4*DIGITS-1:0]   Bcd;
  logic                  busy;
  logic                  done;
`ifdef BIN2BCD_OVERFLOW_EN
  logic                  Overflow;

  modport master (output start, Binary, input Bcd, busy, done, Overflow);
  modport slave  (input start, Binary, output Bcd, busy, done, Overflow);
`else
  modport master (output start, Binary, input Bcd, busy, done);
  modport slave  (input start, Binary, output Bcd, busy, done);
`endif
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);
  assign dout = (din >= bcd_digit_t'(ADJ_THRESHOLD)) ? din + bcd_digit_t'(ADJ_ADD) : din;
endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD encoder, one input bit per clock.
// Optional BIN2BCD_OVERFLOW_EN adds an Overflow flag (input > 10^DIGITS-1).
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  binary_to_bcd_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int BW = BCD_DIGIT_W*DIGITS;

  state_t                               state_q, state_d;
  logic [WIDTH-1:0]                     sr_q;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   scr_q, adj;
  logic [BW-1:0]                        scr_nxt;
  logic                                 carry_unused;
  logic [CW-1:0]                        cnt_q;
  logic [BW-1:0]                        bcd_q;
  logic                                 done_q;
  logic                                 load, fin;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adjust u_adj (.din(scr_q[d]), .dout(adj[d]));
  end

  // Carry out of the top digit is a multiple of 10^DIGITS and is dropped.
  assign {carry_unused, scr_nxt} = {adj, sr_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) begin
               load    = 1'b1;
               state_d = SHIFT;
             end
      SHIFT: if (cnt_q == CW'(1)) begin
               fin     = 1'b1;
               state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (load) begin
        sr_q  <= bus.Binary;
        scr_q <= '0;
        cnt_q <= CW'(WIDTH);
      end else if (state_q == SHIFT) begin
        sr_q  <= sr_q << 1;
        scr_q <= scr_nxt;
        cnt_q <= cnt_q - 1'b1;
        if (fin) bcd_q <= scr_nxt;
      end
    end
  end

`ifdef BIN2BCD_OVERFLOW_EN
  localparam int BCD_MAX = 10**DIGITS - 1;
  logic ovf_lat_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_lat_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (load) ovf_lat_q <= (int'(bus.Binary) > BCD_MAX);
      if (fin)  ovf_q     <= ovf_lat_q;
    end
  end

  assign bus.Overflow = ovf_q;
`endif

  assign bus.Bcd  = bcd_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench for binary_to_bcd_seq against a decimal-arithmetic model.
module tb_binary_to_bcd_seq;
  localparam int W = 7;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  binary_to_bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();
  binary_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [4*D-1:0] model_bcd(input int v);
    int m;
    m = v % 100;
    return {4'(m / 10), 4'(m % 10)};
  endfunction

  // Pulse start for the accepting edge; returns #1 after it.
  task automatic issue(input logic [W-1:0] v);
    bus.start  = 1'b1;
    bus.Binary = v;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  // Follows a conversion from edge 0 to the done edge. mode 1: extra start mid-flight,
  // mode 2: Binary scrambled every cycle.
  task automatic wait_result(input int v, input int mode);
    logic [4*D-1:0] exp;
    exp = model_bcd(v);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL accept v=%0d busy=%b done=%b want busy=1 done=0", v, bus.busy, bus.done);
    end
    for (int k = 1; k < W; k++) begin
      if (mode == 1 && k == 3) begin bus.start = 1'b1; bus.Binary = 7'd10; end
      if (mode == 1 && k == 4) bus.start = 1'b0;
      if (mode == 2) bus.Binary = W'($urandom);
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL shift v=%0d edge=%0d busy=%b done=%b want busy=1 done=0",
                 v, k, bus.busy, bus.done);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.Bcd !== exp) begin
      errors++;
      $display("FAIL result v=%0d done=%b busy=%b bcd=%h want done=1 busy=0 bcd=%h",
               v, bus.done, bus.busy, bus.Bcd, exp);
    end
`ifdef BIN2BCD_OVERFLOW_EN
    checks++;
    if (bus.Overflow !== (v > 99)) begin
      errors++;
      $display("FAIL overflow v=%0d got=%b want=%b", v, bus.Overflow, (v > 99));
    end
`endif
  endtask

  // Confirms idle with the result held and no stray done.
  task automatic check_idle(input int v, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Bcd !== model_bcd(v)) begin
        errors++;
        $display("FAIL idle v=%0d done=%b busy=%b bcd=%h want done=0 busy=0 bcd=%h",
                 v, bus.done, bus.busy, bus.Bcd, model_bcd(v));
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.Binary = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.Bcd !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset bcd=%h busy=%b done=%b want 00/0/0", bus.Bcd, bus.busy, bus.done);
    end
`ifdef BIN2BCD_OVERFLOW_EN
    checks++;
    if (bus.Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got=%b want=0", bus.Overflow);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    check_idle(0, 2);
  endtask

  task automatic test_directed();
    int vals[6] = '{45, 0, 99, 127, 63, 100};
    foreach (vals[i]) begin
      issue(W'(vals[i]));
      wait_result(vals[i], 0);
      check_idle(vals[i], 2);
    end
  endtask

  task automatic test_busy_ignore();
    issue(7'd23);
    wait_result(23, 1);
    check_idle(23, W + 2);
  endtask

  task automatic test_binary_change();
    issue(7'd81);
    wait_result(81, 2);
    bus.Binary = '0;
    check_idle(81, 2);
  endtask

  task automatic test_back_to_back();
    issue(7'd36);
    wait_result(36, 0);
    issue(7'd58);
    wait_result(58, 0);
    check_idle(58, 1);
  endtask

  task automatic test_reset_abort();
    issue(7'd54);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.Bcd !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort bcd=%h busy=%b done=%b want 00/0/0", bus.Bcd, bus.busy, bus.done);
    end
    @(negedge clk); rst_n = 1'b1;
    check_idle(0, W + 2);
    issue(7'd29);
    wait_result(29, 0);
    check_idle(29, 1);
  endtask

  task automatic test_random();
    int v;
    bit chain;
    for (int n = 0; n < 30; n++) begin
      v = int'($urandom_range(0, (1 << W) - 1));
      issue(W'(v));
      wait_result(v, 0);
      chain = 1'($urandom);
      if (!chain) check_idle(v, int'($urandom_range(1, 3)));
    end
    check_idle(v, 1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_binary_change();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end
endmodule
